// File: rtl/calc_cmd_driver.sv
// calc_cmd_driver: command sequencer for the tt_um_calculator_chip.
// Queues (op, operand) commands in a small FIFO, replays each with a one-cycle
// Enter press followed by a release, and captures the calculator result.
// Optional feature macro: CALC_DRV_SHADOW_EN (shadow accumulator that flags
// any disagreement between the calculator result and an internal model).
module calc_cmd_driver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_num,
    output logic [7:0] calc_num,
    output logic [1:0] calc_op,
    output logic       calc_enter,
    input  logic [7:0] calc_result,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       mismatch
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_SAMPLE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;

    // FIFO entry layout: {op[1:0], num[7:0]}
    logic [9:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [9:0]  head_s;

    logic [7:0]  calc_num_r;
    logic [1:0]  calc_op_r;
    logic        calc_enter_r;
    logic        res_valid_r;
    logic [7:0]  res_data_r;

    logic [7:0]  calc_num_nx_s;
    logic [1:0]  calc_op_nx_s;
    logic        calc_enter_nx_s;
    logic        res_valid_nx_s;
    logic [7:0]  res_data_nx_s;

    // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_s  = cmd_valid && !full_s;
    assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];

    assign cmd_ready  = !full_s;
    assign busy       = !empty_s || (state_r != ST_IDLE);
    assign calc_num   = calc_num_r;
    assign calc_op    = calc_op_r;
    assign calc_enter = calc_enter_r;
    assign res_valid  = res_valid_r;
    assign res_data   = res_data_r;

    // FIFO storage write; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= {cmd_op, cmd_num};
        end
    end

    // FIFO pointers; push and pop in the same cycle are both honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and next-output logic for the Enter press/release sequencer.
    always_comb begin
        state_nx_s      = state_r;
        pop_s           = 1'b0;
        calc_num_nx_s   = calc_num_r;
        calc_op_nx_s    = calc_op_r;
        calc_enter_nx_s = 1'b0;
        res_valid_nx_s  = 1'b0;
        res_data_nx_s   = res_data_r;
        case (state_r)
            ST_IDLE, ST_SAMPLE: begin
                if (!empty_s) begin
                    pop_s           = 1'b1;
                    calc_num_nx_s   = head_s[7:0];
                    calc_op_nx_s    = head_s[9:8];
                    calc_enter_nx_s = 1'b1;
                    state_nx_s      = ST_DRIVE;
                end else begin
                    state_nx_s      = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // Enter drops here; the calculator has sampled it this cycle.
                state_nx_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Calculator output now reflects the operation just entered.
                res_data_nx_s  = calc_result;
                res_valid_nx_s = 1'b1;
                state_nx_s     = ST_SAMPLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and registered calculator/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            calc_num_r   <= 8'd0;
            calc_op_r    <= 2'd0;
            calc_enter_r <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            calc_num_r   <= calc_num_nx_s;
            calc_op_r    <= calc_op_nx_s;
            calc_enter_r <= calc_enter_nx_s;
            res_valid_r  <= res_valid_nx_s;
            res_data_r   <= res_data_nx_s;
        end
    end

`ifdef CALC_DRV_SHADOW_EN
    logic [7:0] shadow_acc_r;
    logic       mismatch_r;

    // Reference behaviour of the calculator for one Enter press, mod 256.
    function automatic logic [7:0] calc_model(input logic [1:0] op,
                                              input logic [7:0] num,
                                              input logic [7:0] acc);
        logic [7:0] res;
        case (op)
            2'b00:   res = num + acc;
            2'b01:   res = num - acc;
            2'b10:   res = num | acc;
            2'b11:   res = (num == acc) ? 8'd1 : 8'd0;
            default: res = acc;
        endcase
        return res;
    endfunction

    // Shadow accumulator steps with the calculator; any disagreement is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_acc_r <= 8'd0;
            mismatch_r   <= 1'b0;
        end else begin
            if (state_r == ST_DRIVE) begin
                shadow_acc_r <= calc_model(calc_op_r, calc_num_r, shadow_acc_r);
            end
            if ((state_r == ST_RELEASE) && (calc_result != shadow_acc_r)) begin
                mismatch_r <= 1'b1;
            end
        end
    end

    assign mismatch = mismatch_r;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed testbench for calc_cmd_driver with a behavioural calculator model.
module tb_calc_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_num = 8'd0;
    logic [7:0] calc_num;
    logic [1:0] calc_op;
    logic       calc_enter;
    logic [7:0] calc_result;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic       mismatch;

    int total = 0;
    int bad   = 0;

`ifdef CALC_DRV_SHADOW_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    calc_cmd_driver #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_num    (cmd_num),
        .calc_num   (calc_num),
        .calc_op    (calc_op),
        .calc_enter (calc_enter),
        .calc_result(calc_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    // Calculator: operates once per Enter press, re-arms after release.
    logic [7:0] acc_m;
    logic       wait_m;
    logic       force_aa = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            acc_m  <= 8'd0;
            wait_m <= 1'b0;
        end else if (calc_enter && !wait_m) begin
            wait_m <= 1'b1;
            case (calc_op)
                2'b00:   acc_m <= calc_num + acc_m;
                2'b01:   acc_m <= calc_num - acc_m;
                2'b10:   acc_m <= calc_num | acc_m;
                default: acc_m <= (calc_num == acc_m) ? 8'd1 : 8'd0;
            endcase
        end else if (!calc_enter) begin
            wait_m <= 1'b0;
        end
    end

    assign calc_result = force_aa ? 8'hAA : acc_m;

    // Result collector and event counters, sampled away from the rising edge.
    logic [7:0] res_q[$];
    int enter_cnt = 0;
    int rv_cnt    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                res_q.push_back(res_data);
                rv_cnt = rv_cnt + 1;
            end
            if (calc_enter) enter_cnt = enter_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer a command until accepted; reports how many cycles it was stalled.
    task automatic push(input logic [1:0] op, input logic [7:0] num, output int stalls);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_num   = num;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
        stalls    = n;
    endtask

    task automatic wait_res(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, {31'd0, res_valid}, 32'd1);
        chk(tag, {24'd0, res_data}, {24'd0, exp});
        tick();
    endtask

    initial begin
        int st;
        int n;
        int e0;
        int r0;
        logic [7:0] exp_seq [7];

        // Reset and idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("idle_enter", {31'd0, calc_enter}, 32'd0);
            tick();
        end
        chk("idle_busy",  {31'd0, busy},      32'd0);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_num",   {24'd0, calc_num},  32'd0);
        chk("idle_op",    {30'd0, calc_op},   32'd0);
        chk("idle_rv",    {31'd0, res_valid}, 32'd0);
        chk("idle_rd",    {24'd0, res_data},  32'd0);
        chk("idle_mm",    {31'd0, mismatch},  32'd0);

        // add 5 pushed at edge N, sub 3 at edge N+1; cycle-exact timing.
        push(2'b00, 8'd5, st);           // edge N
        chk("t_n_enter", {31'd0, calc_enter}, 32'd0);
        chk("t_n_busy",  {31'd0, busy},       32'd1);
        push(2'b01, 8'd3, st);           // edge N+1
        chk("t_n1_enter", {31'd0, calc_enter}, 32'd1);
        chk("t_n1_num",   {24'd0, calc_num},   32'd5);
        chk("t_n1_op",    {30'd0, calc_op},    32'd0);
        tick();                          // N+2
        chk("t_n2_enter", {31'd0, calc_enter}, 32'd0);
        tick();                          // N+3
        chk("t_n3_enter", {31'd0, calc_enter}, 32'd0);
        chk("t_n3_rv",    {31'd0, res_valid},  32'd1);
        chk("t_n3_rd",    {24'd0, res_data},   32'h05);
        tick();                          // N+4
        chk("t_n4_rv",    {31'd0, res_valid},  32'd0);
        chk("t_n4_enter", {31'd0, calc_enter}, 32'd1);
        chk("t_n4_num",   {24'd0, calc_num},   32'd3);
        chk("t_n4_op",    {30'd0, calc_op},    32'd1);
        tick();                          // N+5
        chk("t_n5_enter", {31'd0, calc_enter}, 32'd0);
        tick();                          // N+6
        chk("t_n6_rv",    {31'd0, res_valid},  32'd1);
        chk("t_n6_rd",    {24'd0, res_data},   32'hFE);
        chk("t_n6_hold",  {24'd0, calc_num},   32'd3);
        tick();
        tick();
        chk("t_done_busy", {31'd0, busy}, 32'd0);

        // Equality operations.
        do_reset();
        push(2'b00, 8'd5, st);
        wait_res("eq_add5", 8'h05);
        push(2'b11, 8'd5, st);
        wait_res("eq_5", 8'h01);
        push(2'b11, 8'd7, st);
        wait_res("eq_7", 8'h00);

        // FIFO fill: first command in flight, then six more back to back.
        do_reset();
        res_q.delete();
        push(2'b00, 8'd1, st);           // X
        push(2'b00, 8'd2, st);           // A
        push(2'b10, 8'h10, st);          // B
        push(2'b01, 8'h20, st);          // C
        push(2'b11, 8'h0D, st);          // D
        push(2'b00, 8'h40, st);          // E, fills the FIFO
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        push(2'b01, 8'h50, st);          // F, must wait for a pop
        chk("full_stalls", st, 32'd2);
        n = 0;
        while (res_q.size() < 7 && n < 60) begin
            tick();
            n++;
        end
        chk("order_count", res_q.size(), 32'd7);
        exp_seq = '{8'h01, 8'h03, 8'h13, 8'h0D, 8'h01, 8'h41, 8'h0F};
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("order_%0d", i),
                (i < res_q.size()) ? {24'd0, res_q[i]} : 32'hFFFF_FFFF,
                {24'd0, exp_seq[i]});
        end

        // Shadow mismatch detection.
        do_reset();
        force_aa = 1'b1;
        push(2'b00, 8'd1, st);
        wait_res("mm_res", 8'hAA);
        force_aa = 1'b0;
        chk("mm_set", {31'd0, mismatch}, {31'd0, EXP_MM});
        push(2'b00, 8'd1, st);
        wait_res("mm_res2", 8'h02);
        chk("mm_sticky", {31'd0, mismatch}, {31'd0, EXP_MM});
        do_reset();
        chk("mm_clear", {31'd0, mismatch}, 32'd0);

        // Reset during DRIVE of the second command with two commands queued.
        push(2'b00, 8'd1, st);           // edge1
        push(2'b00, 8'd2, st);           // edge2
        push(2'b00, 8'd3, st);           // edge3
        push(2'b00, 8'd4, st);           // edge4
        tick();                          // edge5: second command in DRIVE
        chk("rd_drive_enter", {31'd0, calc_enter}, 32'd1);
        chk("rd_drive_busy",  {31'd0, busy},       32'd1);
        rst = 1'b1;
        tick();                          // edge6: reset sampled
        rst = 1'b0;
        chk("rd_enter", {31'd0, calc_enter}, 32'd0);
        chk("rd_busy",  {31'd0, busy},       32'd0);
        chk("rd_ready", {31'd0, cmd_ready},  32'd1);
        chk("rd_rv",    {31'd0, res_valid},  32'd0);
        chk("rd_num",   {24'd0, calc_num},   32'd0);
        e0 = enter_cnt;
        r0 = rv_cnt;
        for (int i = 0; i < 8; i++) tick();
        chk("rd_no_enter", enter_cnt - e0, 32'd0);
        chk("rd_no_rv",    rv_cnt - r0,    32'd0);
        chk("rd_idle",     {31'd0, busy},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
